// File: rtl/com_to_in_if.sv
// com_to_in_if: oversampled serial receiver signal bundle.
interface com_to_in_if;
    logic       enable;
    logic       rx;
    logic [7:0] data;
    logic       isReady;
    logic       parityError;
    logic       frameError;
    logic       isBusy;

    modport master (
        output enable, rx,
        input  data, isReady, parityError, frameError, isBusy
    );

    modport slave (
        input  enable, rx,
        output data, isReady, parityError, frameError, isBusy
    );
endinterface

// File: rtl/com_to_in.sv
// com_to_in: oversampled 8E1 serial receiver with parity and stop-bit checking.
module com_to_in #(
    parameter int OVERSAMPLE = 16
) (
    input logic        clk,
    input logic        reset_n,
    com_to_in_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} stateT;

    stateT         state, stateNext;
    logic          rxMeta, rxs;
    logic [CW-1:0] cnt, cntNext;
    logic [2:0]    idx, idxNext;
    logic [7:0]    shift, shiftNext;
    logic [7:0]    dataReg, dataNext;
    logic          parCand, parCandNext;
    logic          parErr, parErrNext;
    logic          frmErr, frmErrNext;
    logic          lastTick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxMeta <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            rxMeta <= bus.rx;
            rxs    <= rxMeta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            dataReg <= '0;
            parCand <= 1'b0;
            parErr  <= 1'b0;
            frmErr  <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            idx     <= idxNext;
            shift   <= shiftNext;
            dataReg <= dataNext;
            parCand <= parCandNext;
            parErr  <= parErrNext;
            frmErr  <= frmErrNext;
        end
    end

    assign lastTick = bus.enable && cnt == FULL_LAST;

    // Results are loaded on entry to DONE so they are already valid while isReady is high.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        idxNext     = idx;
        shiftNext   = shift;
        dataNext    = dataReg;
        parCandNext = parCand;
        parErrNext  = parErr;
        frmErrNext  = frmErr;
        case (state)
            IDLE: if (bus.enable && !rxs) begin
                stateNext = START;
                cntNext   = '0;
            end
            START: if (bus.enable) begin
                if (cnt == HALF_LAST) begin
                    cntNext   = '0;
                    idxNext   = '0;
                    stateNext = rxs ? IDLE : DATA;
                end else cntNext = cnt + ONE;
            end
            DATA: begin
                if (bus.enable) cntNext = cnt + ONE;
                if (lastTick) begin
                    shiftNext[idx] = rxs;
                    idxNext        = idx + 3'd1;
                    stateNext      = idx == 3'd7 ? PARITY : DATA;
                end
            end
            PARITY: begin
                if (bus.enable) cntNext = cnt + ONE;
                if (lastTick) begin
                    parCandNext = ^shift ^ rxs;
                    stateNext   = STOP;
                end
            end
            STOP: begin
                if (bus.enable) cntNext = cnt + ONE;
                if (lastTick) begin
                    dataNext   = shift;
                    parErrNext = parCand;
                    frmErrNext = !rxs;
                    stateNext  = DONE;
                end
            end
            DONE: begin
                cntNext   = '0;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.data        = dataReg;
    assign bus.parityError = parErr;
    assign bus.frameError  = frmErr;
    assign bus.isReady     = state == DONE;
    assign bus.isBusy      = state != IDLE;
endmodule

// File: tb/tb_com_to_in.sv
// tb_com_to_in: directed and randomized frames checked against a per-frame reference model.
module tb_com_to_in;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    com_to_in_if bus();
    com_to_in #(.OVERSAMPLE(OS)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int         errors = 0;
    int         checks = 0;
    int         enPeriod = 1;
    logic [9:0] got[$];
    logic       prevReady = 1'b0;
    logic [7:0] expData = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.isReady) begin
            checks++;
            assert (!prevReady) else begin
                errors++;
                $error("FAIL isReadyTwice observed=1 expected=0");
            end
            got.push_back({bus.data, bus.parityError, bus.frameError});
        end
        prevReady = bus.isReady;
    end

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.enable = 1'b1;
            @(negedge clk);
            bus.enable = 1'b0;
            repeat (enPeriod - 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        ticks(n);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic p, input logic s);
        logic [10:0] bits;
        bits = {s, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.rx = bits[i];
            ticks(OS);
        end
    endtask

    task automatic expectFrame(input string tag, input logic [7:0] b, input logic p, input logic s);
        logic [9:0] r;
        chk({tag, ".pulses"}, got.size(), 1);
        if (got.size() > 0) begin
            r = got.pop_front();
            chk({tag, ".data"}, r[9:2], b);
            chk({tag, ".parityError"}, r[1], (^b) ^ p);
            chk({tag, ".frameError"}, r[0], !s);
            expData = b;
        end
        got.delete();
        chk({tag, ".dataHeld"}, bus.data, b);
    endtask

    task automatic checkReset(input string tag);
        chk({tag, ".data"}, bus.data, 8'h00);
        chk({tag, ".isReady"}, bus.isReady, 1'b0);
        chk({tag, ".parityError"}, bus.parityError, 1'b0);
        chk({tag, ".frameError"}, bus.frameError, 1'b0);
        chk({tag, ".isBusy"}, bus.isBusy, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        logic       p, s;
        bus.enable = 1'b0;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        checkReset("reset");
        reset_n = 1'b1;
        idle(OS);

        sendFrame(8'hA5, 1'b0, 1'b1);
        expectFrame("a5", 8'hA5, 1'b0, 1'b1);
        chk("a5.isBusy", bus.isBusy, 1'b0);

        sendFrame(8'h01, 1'b0, 1'b1);
        expectFrame("parity01", 8'h01, 1'b0, 1'b1);

        sendFrame(8'h3C, 1'b0, 1'b0);
        expectFrame("stop3c", 8'h3C, 1'b0, 1'b0);
        idle(2 * OS);
        chk("stop3c.noSecond", got.size(), 0);
        chk("stop3c.isBusy", bus.isBusy, 1'b0);

        bus.rx = 1'b0;
        ticks(4);
        chk("glitch.busyDuring", bus.isBusy, 1'b1);
        idle(OS);
        chk("glitch.pulses", got.size(), 0);
        chk("glitch.isBusy", bus.isBusy, 1'b0);
        chk("glitch.data", bus.data, expData);

        sendFrame(8'h55, 1'b0, 1'b1);
        expectFrame("b2b55", 8'h55, 1'b0, 1'b1);
        sendFrame(8'hAA, 1'b0, 1'b1);
        expectFrame("b2bAA", 8'hAA, 1'b0, 1'b1);

        enPeriod = 3;
        sendFrame(8'h55, 1'b0, 1'b1);
        sendFrame(8'hAA, 1'b0, 1'b1);
        chk("slow.pulses", got.size(), 2);
        if (got.size() == 2) begin
            chk("slow.first", got[0], {8'h55, 2'b00});
            chk("slow.second", got[1], {8'hAA, 2'b00});
        end
        got.delete();
        chk("slow.data", bus.data, 8'hAA);
        expData = 8'hAA;

        for (int n = 0; n < 12; n++) begin
            enPeriod = $urandom_range(1, 3);
            b = 8'($urandom);
            p = 1'($urandom);
            s = $urandom_range(0, 3) != 0;
            sendFrame(b, p, s);
            expectFrame("random", b, p, s);
            idle(s ? $urandom_range(0, 2) : 2 * OS);
        end

        enPeriod = 1;
        idle(OS);
        bus.rx = 1'b0;
        ticks(OS);
        bus.rx = 1'b1;
        ticks(3 * OS);
        chk("abort.busyInData", bus.isBusy, 1'b1);
        reset_n = 1'b0;
        bus.rx = 1'b0;
        repeat (2) @(negedge clk);
        checkReset("abort.reset");
        expData = 8'h00;
        got.delete();
        reset_n = 1'b1;
        sendFrame(8'h12, 1'b0, 1'b1);
        expectFrame("after12", 8'h12, 1'b0, 1'b1);
        idle(2 * OS);
        chk("after12.noExtra", got.size(), 0);
        chk("after12.isBusy", bus.isBusy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/com_to_in.md
COM_TO_IN -- requirements
Module: com_to_in

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, number of enable ticks per serial bit; power of two, 4..64.
REQ-002 clk  input  1  rising-edge system clock, the only clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  oversample tick; the receive FSM advances only in cycles with enable=1.
REQ-005 rx  input  1  serial line, idle high; frame = start(0), 8 data bits LSB first, even-parity bit, stop(1).
REQ-006 data  output  8  last received byte; holds until the next frame completes.
REQ-007 isReady  output  1  one-clk pulse marking a completed frame.
REQ-008 parityError  output  1  parity status of the last frame; valid with isReady and held after.
REQ-009 frameError  output  1  stop-bit status of the last frame; valid with isReady and held after.
REQ-010 isBusy  output  1  high while a frame is in progress (state other than IDLE).

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer, reset to 1; all FSM decisions use the synchronized value rxs.
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP, DONE; an oversample counter of log2(OVERSAMPLE) bits and a 3-bit bit index.
REQ-013 IDLE: on enable with rxs=0 -> START, counter cleared.
REQ-014 START: after OVERSAMPLE/2 enable ticks, recheck rxs. If 0 -> DATA with counter and index cleared. If 1 -> IDLE as a glitch, with no outputs changed.
REQ-015 DATA: every OVERSAMPLE enable ticks, sample rxs into shift-register bit [index]. After index 7 -> PARITY.
REQ-016 PARITY: after OVERSAMPLE ticks, sample the parity bit. The computed error = XOR of the 8 data bits XOR the sampled bit; 1 means a mismatch under even parity.
REQ-017 STOP: after OVERSAMPLE ticks, sample the stop bit. frameError candidate = NOT rxs. Then -> DONE.
REQ-018 DONE: lasts exactly one clk regardless of enable. In it: data <= shift register, parityError and frameError <= candidates, isReady=1. Then -> IDLE.
REQ-019 isReady SHALL be high only in DONE; it SHALL never be high for two consecutive clks.
REQ-020 data, parityError and frameError SHALL change only in DONE. A frame with errors still updates data.
REQ-021 With enable=0 the FSM and counters SHALL hold their values; the synchronizer keeps running.
REQ-022 Back-to-back frames: a new start bit SHALL be detected from the first enable tick after DONE. No extra idle bit is required beyond the stop half-bit.
REQ-023 Break or stuck-low line: a frame with stop=0 completes with frameError=1. IDLE then immediately re-detects rxs=0 as a new start.
REQ-024 Timing: the start bit is sampled mid-bit at OVERSAMPLE/2 ticks; each later bit is sampled exactly OVERSAMPLE ticks after the previous sample.

Reset
REQ-025 While reset_n=0, asynchronously: state=IDLE, counters=0, synchronizer=1, data=0x00, isReady=0, parityError=0, frameError=0, isBusy=0.
REQ-026 Reset deasserting mid-frame SHALL abandon the frame. No isReady is produced for it, and reception resumes in IDLE.
REQ-027 After reset release, a line held low SHALL be treated as a start bit.

Verification
REQ-028 OVERSAMPLE=16, enable=1 every clk, frame 0xA5 with parity 0 and stop 1 -> one isReady pulse, data=0xA5, parityError=0, frameError=0, isBusy low after DONE.
REQ-029 Frame 0x01 sent with parity bit 0 -> data=0x01, parityError=1, frameError=0.
REQ-030 Frame 0x3C with stop bit 0 -> data=0x3C, frameError=1. Then rx high -> returns to IDLE with no second isReady.
REQ-031 rx low for 4 enable ticks, then high -> no isReady, isBusy drops back to 0, data unchanged.
REQ-032 Two frames 0x55 then 0xAA sent back-to-back; separately, enable asserted 1 clk in 3 -> two isReady pulses in order, data 0x55 then 0xAA, no errors.
REQ-033 reset_n pulsed low during DATA of frame 0xFF, then a clean frame 0x12 -> only one isReady, with data=0x12 and no errors.
